// File: rtl/chip8_alu_exec_if.sv
// Command, external-write and read-port bundle between the CPU decode stage and chip8_alu_exec.
// master = CPU side, slave = sequencer side.
interface chip8_alu_exec_if #(
   parameter int unsigned DATA_W = 8
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [15:0]       cmd_op;
   logic              done;
   logic              err;
   logic [3:0]        rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              ext_we;
   logic [3:0]        ext_addr;
   logic [DATA_W-1:0] ext_data;

   modport master (
      output cmd_valid, cmd_op, rd_addr, ext_we, ext_addr, ext_data,
      input  cmd_ready, done, err, rd_data
   );

   modport slave (
      input  cmd_valid, cmd_op, rd_addr, ext_we, ext_addr, ext_data,
      output cmd_ready, done, err, rd_data
   );
endinterface

// File: rtl/chip8_alu_exec.sv
// CHIP-8 8XYN sequencer: owns V0-VF, drives Chip8_ALU, writes result to Vx and flag to VF.
// ALU_f codes: OR=0 AND=1 XOR=2 ADD=3 MINUS=4 RSHIFT=5 LSHIFT=6. Option: CHIP8_VF_RESET_EN.
module chip8_alu_exec #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ALU_W  = 16,
   parameter int unsigned NREGS  = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   chip8_alu_exec_if.slave      bus,
   output logic [ALU_W-1:0]     alu_in1,
   output logic [ALU_W-1:0]     alu_in2,
   output logic [2:0]           alu_sel,
   input  logic [ALU_W-1:0]     alu_out,
   input  logic                 alu_carry
);

   localparam logic [2:0] ALU_F_OR     = 3'd0;
   localparam logic [2:0] ALU_F_AND    = 3'd1;
   localparam logic [2:0] ALU_F_XOR    = 3'd2;
   localparam logic [2:0] ALU_F_ADD    = 3'd3;
   localparam logic [2:0] ALU_F_MINUS  = 3'd4;
   localparam logic [2:0] ALU_F_RSHIFT = 3'd5;
   localparam logic [2:0] ALU_F_LSHIFT = 3'd6;

   typedef enum logic [1:0] {StIdle, StExec, StWbRes, StWbFlag} state_e;

   state_e            state_q, state_d;
   logic [3:0]        x_q, x_d;
   logic [3:0]        n_q, n_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              flag_q, flag_d;
   logic [ALU_W-1:0]  in1_q, in1_d;
   logic [ALU_W-1:0]  in2_q, in2_d;
   logic [2:0]        sel_q, sel_d;
   logic [DATA_W-1:0] regs_q [NREGS];
   logic [DATA_W-1:0] regs_d [NREGS];

   logic [DATA_W-1:0] vx, vy;
   logic [ALU_W-1:0]  op_a, op_b;
   logic              unused_bits;

   function automatic logic is_legal(input logic [3:0] n);
      return (n <= 4'h7) || (n == 4'hE);
   endfunction

   function automatic logic is_flag_op(input logic [3:0] n);
      logic f;
      case (n)
         4'h4, 4'h5, 4'h6, 4'h7, 4'hE: f = 1'b1;
`ifdef CHIP8_VF_RESET_EN
         4'h1, 4'h2, 4'h3:             f = 1'b1;
`endif
         default:                      f = 1'b0;
      endcase
      return f;
   endfunction

   // Operands come from the pre-write register values even if ext_we hits the same edge.
   assign vx   = regs_q[bus.cmd_op[11:8]];
   assign vy   = regs_q[bus.cmd_op[7:4]];
   assign op_a = {{(ALU_W-DATA_W){1'b0}}, vx};
   assign op_b = {{(ALU_W-DATA_W){1'b0}}, vy};

   assign unused_bits = ^{bus.cmd_op[15:12], alu_out[ALU_W-1:DATA_W+1]};

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      n_d     = n_q;
      a_d     = a_q;
      res_d   = res_q;
      flag_d  = flag_q;
      in1_d   = in1_q;
      in2_d   = in2_q;
      sel_d   = sel_q;
      regs_d  = regs_q;

      case (state_q)
         StIdle: begin
            if (bus.ext_we) begin
               regs_d[bus.ext_addr] = bus.ext_data;
            end
            if (bus.cmd_valid) begin
               x_d     = bus.cmd_op[11:8];
               n_d     = bus.cmd_op[3:0];
               a_d     = vx;
               in1_d   = op_a;
               in2_d   = op_b;
               sel_d   = ALU_F_OR;
               state_d = StExec;
               case (bus.cmd_op[3:0])
                  4'h0: begin
                     in1_d = op_b;
                     in2_d = '0;
                  end
                  4'h2: sel_d = ALU_F_AND;
                  4'h3: sel_d = ALU_F_XOR;
                  4'h4: sel_d = ALU_F_ADD;
                  4'h5: sel_d = ALU_F_MINUS;
                  4'h6: begin
                     sel_d = ALU_F_RSHIFT;
                     in2_d = ALU_W'(1);
                  end
                  4'h7: begin
                     sel_d = ALU_F_MINUS;
                     in1_d = op_b;
                     in2_d = op_a;
                  end
                  4'hE: begin
                     sel_d = ALU_F_LSHIFT;
                     in2_d = ALU_W'(1);
                  end
                  default: sel_d = ALU_F_OR;
               endcase
            end
         end

         StExec: begin
            res_d = alu_out[DATA_W-1:0];
            case (n_q)
               4'h4:       flag_d = alu_out[DATA_W];
               4'h5, 4'h7: flag_d = alu_carry;
               4'h6:       flag_d = a_q[0];
               4'hE:       flag_d = a_q[DATA_W-1];
               default:    flag_d = 1'b0;
            endcase
            state_d = StWbRes;
         end

         StWbRes: begin
            if (is_legal(n_q)) begin
               regs_d[x_q] = res_q;
            end
            state_d = StWbFlag;
         end

         StWbFlag: begin
            // Flag lands after the result, so x=F ends with VF holding the flag.
            if (is_flag_op(n_q)) begin
               regs_d[NREGS-1] = {{(DATA_W-1){1'b0}}, flag_q};
            end
            state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         x_q     <= '0;
         n_q     <= '0;
         a_q     <= '0;
         res_q   <= '0;
         flag_q  <= 1'b0;
         in1_q   <= '0;
         in2_q   <= '0;
         sel_q   <= ALU_F_OR;
         for (int i = 0; i < int'(NREGS); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         n_q     <= n_d;
         a_q     <= a_d;
         res_q   <= res_d;
         flag_q  <= flag_d;
         in1_q   <= in1_d;
         in2_q   <= in2_d;
         sel_q   <= sel_d;
         regs_q  <= regs_d;
      end
   end

   assign bus.cmd_ready = (state_q == StIdle);
   assign bus.done      = (state_q == StWbFlag);
   assign bus.err       = (state_q == StWbFlag) && !is_legal(n_q);
   assign bus.rd_data   = regs_q[bus.rd_addr];
   assign alu_in1       = in1_q;
   assign alu_in2       = in2_q;
   assign alu_sel       = sel_q;

endmodule

// File: tb/tb_chip8_alu_exec.sv
// Directed bench for chip8_alu_exec with a behavioural Chip8_ALU model on the ALU ports.
module tb_chip8_alu_exec;

   localparam logic [2:0] F_OR = 3'd0, F_AND = 3'd1, F_XOR = 3'd2, F_ADD = 3'd3;
   localparam logic [2:0] F_MINUS = 3'd4, F_RSHIFT = 3'd5, F_LSHIFT = 3'd6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] alu_in1, alu_in2, alu_out;
   logic [2:0]  alu_sel;
   logic        alu_carry;

   int          tests_run = 0;
   int          tests_failed = 0;
   logic [2:0]  exec_sel;
   logic [15:0] exec_in1, exec_in2;

   chip8_alu_exec_if #(.DATA_W(8)) bus ();

   chip8_alu_exec #(.DATA_W(8), .ALU_W(16), .NREGS(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .alu_in1   (alu_in1),
      .alu_in2   (alu_in2),
      .alu_sel   (alu_sel),
      .alu_out   (alu_out),
      .alu_carry (alu_carry)
   );

   always #5 clk = ~clk;

   always_comb begin
      alu_out   = 16'h0000;
      alu_carry = 1'b0;
      case (alu_sel)
         F_OR:     alu_out = alu_in1 | alu_in2;
         F_AND:    alu_out = alu_in1 & alu_in2;
         F_XOR:    alu_out = alu_in1 ^ alu_in2;
         F_ADD:    alu_out = alu_in1 + alu_in2;
         F_MINUS: begin
            alu_out   = alu_in1 - alu_in2;
            alu_carry = alu_in1 > alu_in2;
         end
         F_RSHIFT: alu_out = alu_in1 >> alu_in2;
         F_LSHIFT: alu_out = alu_in1 << alu_in2;
         default:  alu_out = 16'h0000;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_reg(input logic [3:0] addr, input logic [7:0] data);
      bus.ext_we   = 1'b1;
      bus.ext_addr = addr;
      bus.ext_data = data;
      @(negedge clk);
      bus.ext_we   = 1'b0;
   endtask

   task automatic check_reg(input string tag, input logic [3:0] addr, input logic [7:0] exp);
      bus.rd_addr = addr;
      #1;
      check_eq(tag, {24'h0, bus.rd_data}, {24'h0, exp});
   endtask

   // Called at a negedge in IDLE; returns at the negedge after the done cycle.
   task automatic run_op(input logic [15:0] op, input logic exp_err);
      int cyc;
      check_eq("ready_idle", {31'h0, bus.cmd_ready}, 32'd1);
      bus.cmd_op    = op;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      cyc = 1;
      exec_sel = alu_sel;
      exec_in1 = alu_in1;
      exec_in2 = alu_in2;
      check_eq("ready_busy", {31'h0, bus.cmd_ready}, 32'd0);
      while (!bus.done && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("latency", cyc, 32'd3);
      check_eq("err", {31'h0, bus.err}, {31'h0, exp_err});
      @(negedge clk);
      check_eq("done_pulse", {31'h0, bus.done}, 32'd0);
   endtask

   initial begin
      int   cyc;
      logic saw_done;
      bus.cmd_valid = 1'b0;
      bus.cmd_op    = 16'h0000;
      bus.rd_addr   = 4'h0;
      bus.ext_we    = 1'b0;
      bus.ext_addr  = 4'h0;
      bus.ext_data  = 8'h00;

      // Reset state
      #12;
      check_eq("rst_ready", {31'h0, bus.cmd_ready}, 32'd1);
      check_eq("rst_done", {31'h0, bus.done}, 32'd0);
      check_eq("rst_err", {31'h0, bus.err}, 32'd0);
      check_eq("rst_sel", {29'h0, alu_sel}, {29'h0, F_OR});
      check_eq("rst_in1", {16'h0, alu_in1}, 32'h0);
      check_eq("rst_in2", {16'h0, alu_in2}, 32'h0);
      @(negedge clk);
      reset = 1'b0;
      check_reg("rst_v0", 4'h0, 8'h00);
      check_reg("rst_vf", 4'hF, 8'h00);

      // Reset while V3 write is pending in WB_RES
      set_reg(4'h1, 8'h01);
      bus.cmd_op    = 16'h8314;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      check_eq("midrst_ready", {31'h0, bus.cmd_ready}, 32'd1);
      check_eq("midrst_done", {31'h0, bus.done}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         saw_done = saw_done | bus.done;
         @(negedge clk);
      end
      check_eq("midrst_no_done", {31'h0, saw_done}, 32'd0);
      check_reg("midrst_v3", 4'h3, 8'h00);
      check_reg("midrst_v1", 4'h1, 8'h00);

      // ADD with carry out of bit 7
      set_reg(4'h1, 8'hFF);
      set_reg(4'h2, 8'h01);
      run_op(16'h8124, 1'b0);
      check_eq("add_sel", {29'h0, exec_sel}, {29'h0, F_ADD});
      check_eq("add_in1", {16'h0, exec_in1}, 32'h00FF);
      check_eq("add_in2", {16'h0, exec_in2}, 32'h0001);
      check_reg("add_v1", 4'h1, 8'h00);
      check_reg("add_vf", 4'hF, 8'h01);

      // SUB borrow, then SUBN
      set_reg(4'h1, 8'h05);
      set_reg(4'h2, 8'h07);
      run_op(16'h8125, 1'b0);
      check_eq("sub_sel", {29'h0, exec_sel}, {29'h0, F_MINUS});
      check_reg("sub_v1", 4'h1, 8'hFE);
      check_reg("sub_vf", 4'hF, 8'h00);
      set_reg(4'h1, 8'h05);
      run_op(16'h8127, 1'b0);
      check_eq("subn_in1", {16'h0, exec_in1}, 32'h0007);
      check_reg("subn_v1", 4'h1, 8'h02);
      check_reg("subn_vf", 4'hF, 8'h01);

      // SUB wrap without borrow flag
      set_reg(4'h5, 8'h00);
      set_reg(4'h6, 8'h01);
      run_op(16'h8565, 1'b0);
      check_reg("subwrap_v5", 4'h5, 8'hFF);
      check_reg("subwrap_vf", 4'hF, 8'h00);

      // Shifts into VF: flag overwrites the result
      set_reg(4'hF, 8'h81);
      run_op(16'h8F06, 1'b0);
      check_eq("shr_sel", {29'h0, exec_sel}, {29'h0, F_RSHIFT});
      check_reg("shr_vf", 4'hF, 8'h01);
      set_reg(4'hF, 8'h81);
      run_op(16'h8F0E, 1'b0);
      check_eq("shl_sel", {29'h0, exec_sel}, {29'h0, F_LSHIFT});
      check_reg("shl_vf", 4'hF, 8'h01);

      // Shifts on an ordinary register
      set_reg(4'h3, 8'h81);
      run_op(16'h8306, 1'b0);
      check_reg("shr_v3", 4'h3, 8'h40);
      check_reg("shr_v3_vf", 4'hF, 8'h01);
      set_reg(4'h3, 8'h40);
      run_op(16'h830E, 1'b0);
      check_reg("shl_v3", 4'h3, 8'h80);
      check_reg("shl_v3_vf", 4'hF, 8'h00);

      // Logic ops and the VF-reset option
      set_reg(4'hF, 8'h55);
      set_reg(4'h1, 8'h0F);
      set_reg(4'h2, 8'h3C);
      run_op(16'h8121, 1'b0);
      check_reg("or_v1", 4'h1, 8'h3F);
`ifdef CHIP8_VF_RESET_EN
      check_reg("or_vf", 4'hF, 8'h00);
`else
      check_reg("or_vf", 4'hF, 8'h55);
`endif
      set_reg(4'h1, 8'h0F);
      run_op(16'h8122, 1'b0);
      check_reg("and_v1", 4'h1, 8'h0C);
      set_reg(4'h1, 8'h0F);
      run_op(16'h8123, 1'b0);
      check_reg("xor_v1", 4'h1, 8'h33);
      run_op(16'h8120, 1'b0);
      check_reg("ld_v1", 4'h1, 8'h3C);

      // Illegal N: err with done, no register change
      set_reg(4'hF, 8'h5A);
      set_reg(4'h1, 8'h12);
      run_op(16'h8129, 1'b1);
      check_reg("ill_v1", 4'h1, 8'h12);
      check_reg("ill_vf", 4'hF, 8'h5A);

      // ext_we while busy is dropped
      set_reg(4'h4, 8'h11);
      bus.cmd_op    = 16'h8120;
      bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.ext_we    = 1'b1;
      bus.ext_addr  = 4'h4;
      bus.ext_data  = 8'hAA;
      cyc = 1;
      while (!bus.done && cyc < 8) begin
         @(negedge clk);
         cyc++;
      end
      bus.ext_we = 1'b0;
      check_eq("busy_latency", cyc, 32'd3);
      @(negedge clk);
      check_reg("busy_v4", 4'h4, 8'h11);

      // ext write and accept on the same edge: operands use the pre-write value
      bus.ext_we   = 1'b1;
      bus.ext_addr = 4'h4;
      bus.ext_data = 8'hAA;
      run_op(16'h8140, 1'b0);
      bus.ext_we   = 1'b0;
      check_reg("same_v1", 4'h1, 8'h11);
      check_reg("same_v4", 4'h4, 8'hAA);
      run_op(16'h8140, 1'b0);
      check_reg("same_v1_next", 4'h1, 8'hAA);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
